// File: rtl/prim_cg_pkg.sv
// prim_cg_pkg: shared state type, stats width and helpers for the clock-gating controller
package prim_cg_pkg;

    typedef enum logic [1:0] {CgRun, CgIdle, CgGated, CgWake} cg_state_e;

    localparam int unsigned StatW = 32;

    function automatic int unsigned cg_max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/prim_cg_chan.sv
// prim_cg_chan: one channel's gating FSM, idle/wake counter, wake ack register and glitch-free enable latch
module prim_cg_chan import prim_cg_pkg::*; #(
    parameter int unsigned IdleCycles = 16,
    parameter int unsigned WakeCycles = 2,
    parameter int unsigned CntW       = $clog2(cg_max(IdleCycles, WakeCycles) + 1)
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic test_en_i,
    input  logic cg_en_i,
    input  logic busy_i,
    input  logic wake_req_i,
    output logic wake_ack_o,
    output logic gated_o,
    output logic clk_o
);

    localparam logic [CntW-1:0] IdleLast = CntW'(IdleCycles - 1);
    localparam logic [CntW-1:0] WakeLast = CntW'(WakeCycles - 1);

    cg_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
    logic            ack_q, ack_d;
    logic            acked_q, acked_d;
    logic            en_q, en_d;
    logic            en_l;

    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    // next state, counter and ack; acked remembers a held request was already answered
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        if (test_en_i) begin
            state_d = CgRun;
            cnt_d   = '0;
        end else begin
            case (state_q)
                CgRun: begin
                    if (!busy_i && cg_en_i && !wake_req_i) begin
                        state_d = CgIdle;
                        cnt_d   = '0;
                    end else begin
                        ack_d = wake_req_i & ~acked_q;
                    end
                end
                CgIdle: begin
                    if (busy_i || !cg_en_i || wake_req_i) begin
                        state_d = CgRun;
                        ack_d   = wake_req_i & ~acked_q;
                    end else if (cnt_q == IdleLast) begin
                        state_d = CgGated;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                CgGated: begin
                    if (wake_req_i || busy_i || !cg_en_i) begin
                        state_d = CgWake;
                        cnt_d   = '0;
                    end
                end
                CgWake: begin
                    if (cnt_q == WakeLast) begin
                        state_d = CgRun;
                        ack_d   = wake_req_i & ~acked_q;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: state_d = CgRun;
            endcase
        end
        acked_d = wake_req_i & (acked_q | ack_d);
        en_d    = (state_d != CgGated) | test_en_i;
    end

    // state registers; reset leaves the clock enabled
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= CgRun;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            acked_q <= 1'b0;
            en_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            acked_q <= acked_d;
            en_q    <= en_d;
        end
    end

    // enable only changes while clk_i is low so clk_o pulses are never truncated
    always_latch begin
        if (!clk_i) en_l = en_q | test_en_i;
    end

    assign clk_o      = clk_i & en_l;
    assign wake_ack_o = ack_q;
    assign gated_o    = (state_q == CgGated);

endmodule

// File: rtl/prim_clock_gate_ctrl.sv
// prim_clock_gate_ctrl: multi-channel auto clock gating; PRIM_CG_STATS_EN adds per-channel gated-cycle counters
module prim_clock_gate_ctrl import prim_cg_pkg::*; #(
    parameter int unsigned NumCh      = 4,
    parameter int unsigned IdleCycles = 16,
    parameter int unsigned WakeCycles = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   test_en_i,
    input  logic [NumCh-1:0]       cg_en_i,
    input  logic [NumCh-1:0]       busy_i,
    input  logic [NumCh-1:0]       wake_req_i,
`ifdef PRIM_CG_STATS_EN
    input  logic                   stats_clr_i,
    output logic [NumCh*StatW-1:0] gated_cnt_o,
`endif
    output logic [NumCh-1:0]       wake_ack_o,
    output logic [NumCh-1:0]       gated_o,
    output logic [NumCh-1:0]       clk_o
);

    localparam int unsigned CntW = $clog2(cg_max(IdleCycles, WakeCycles) + 1);

    for (genvar i = 0; i < NumCh; i++) begin : g_ch
        prim_cg_chan #(
            .IdleCycles (IdleCycles),
            .WakeCycles (WakeCycles),
            .CntW       (CntW)
        ) u_chan (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .test_en_i  (test_en_i),
            .cg_en_i    (cg_en_i[i]),
            .busy_i     (busy_i[i]),
            .wake_req_i (wake_req_i[i]),
            .wake_ack_o (wake_ack_o[i]),
            .gated_o    (gated_o[i]),
            .clk_o      (clk_o[i])
        );
    end

`ifdef PRIM_CG_STATS_EN
    logic [NumCh-1:0][StatW-1:0] stat_q, stat_d;

    // count cycles spent gated, saturating; clear beats increment
    always_comb begin
        stat_d = stat_q;
        for (int c = 0; c < NumCh; c++) begin
            stat_d[c] = stats_clr_i ? '0 : stat_q[c] + StatW'(gated_o[c] & ~(&stat_q[c]));
        end
    end

    // stats registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) stat_q <= '0;
        else         stat_q <= stat_d;
    end

    assign gated_cnt_o = stat_q;
`endif

endmodule
